// File: rtl/riscy_line_adapter_if.sv
// Bundle of cache-side line signals and memory-side burst signals.
// The adapter takes the slave view; the cache/memory environment takes the master view.
interface riscy_line_adapter_if;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  modport slave (
    input  line_read, line_write, line_addr, line_wdata, mem_rdata, mem_resp,
    output line_rdata, line_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output line_read, line_write, line_addr, line_wdata, mem_rdata, mem_resp,
    input  line_rdata, line_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscy_line_adapter.sv
// Converts 256-bit cache line fill/writeback requests into 4-beat 64-bit memory bursts.
// Write wins over read; every output is taken straight from a register.
module riscy_line_adapter (
  input  logic                 clk,
  input  logic                 rst_n,
  riscy_line_adapter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RBURST, WBURST, DONE} state_t;

  state_t       state_q;
  state_t       state_d;
  logic [1:0]   k;
  logic [1:0]   k_inc;
  logic         beat_last;
  logic [255:0] wdata_q;

  assign k_inc     = k + 2'd1;
  assign beat_last = bus.mem_resp && (k == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.line_write)     state_d = WBURST;
        else if (bus.line_read) state_d = RBURST;
      end
      RBURST, WBURST: begin
        if (beat_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and line_resp are decoded from the next state so they are registered yet cycle-exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.line_resp <= 1'b0;
    end else begin
      bus.mem_read  <= (state_d == RBURST);
      bus.mem_write <= (state_d == WBURST);
      bus.line_resp <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k              <= 2'd0;
      wdata_q        <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.line_rdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.line_write) begin
            bus.mem_addr  <= bus.line_addr & 32'hFFFF_FFE0;
            wdata_q       <= bus.line_wdata;
            bus.mem_wdata <= bus.line_wdata[63:0];
            k             <= 2'd0;
          end else if (bus.line_read) begin
            bus.mem_addr  <= bus.line_addr & 32'hFFFF_FFE0;
            k             <= 2'd0;
          end
        end
        RBURST: begin
          if (bus.mem_resp) begin
            bus.line_rdata[{k, 6'd0} +: 64] <= bus.mem_rdata;
            k                               <= k_inc;
          end
        end
        WBURST: begin
          // Next beat is presented as soon as memory takes the current one.
          if (bus.mem_resp) begin
            bus.mem_wdata <= wdata_q[{k_inc, 6'd0} +: 64];
            k             <= k_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscy_line_adapter.sv
// Scoreboard bench for riscy_line_adapter: a small memory model serves bursts and
// compares addresses, write beats, assembled lines and latency against queued expectations.
module tb_riscy_line_adapter;

  logic clk;
  logic rst_n;

  riscy_line_adapter_if bus();

  riscy_line_adapter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [31:0]  addrQ[$];
  logic [63:0]  wrBeatQ[$];
  logic [63:0]  memBeatQ[$];
  logic [255:0] rdExpQ[$];
  logic [255:0] lastRead;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [255:0] wdata, input logic [255:0] rbeats);
    if (wr) begin
      addrQ.push_back({addr[31:5], 5'b0});
      for (int i = 0; i < 4; i++) wrBeatQ.push_back(wdata[64*i +: 64]);
    end
    if (rd) begin
      addrQ.push_back({addr[31:5], 5'b0});
      for (int i = 0; i < 4; i++) memBeatQ.push_back(rbeats[64*i +: 64]);
      rdExpQ.push_back(rbeats);
    end
    bus.line_addr  = addr;
    bus.line_wdata = wdata;
    bus.line_read  = rd;
    bus.line_write = wr;
  endtask

  // Called right after a request is visible to the DUT; ends in the IDLE cycle after DONE.
  task automatic serveBurst(input bit isWrite, input int gap, input bit junkInDone);
    int           cyc;
    int           beat;
    int           gapCnt;
    bit           done;
    logic [31:0]  expAddr;
    logic [63:0]  expBeat;
    logic [255:0] expLine;
    cyc = 0; beat = 0; gapCnt = 0; done = 0;
    expAddr = (addrQ.size() > 0) ? addrQ.pop_front() : 32'hFFFF_FFFF;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.mem_resp = 1'b0;
      if (bus.line_resp) begin
        done = 1;
        checkOutput("latency", cyc, 4 * (gap + 1) + 1);
        checkOutput("done_mem_read", bus.mem_read, 1'b0);
        checkOutput("done_mem_write", bus.mem_write, 1'b0);
        checkOutput("done_beats", beat, 4);
        if (isWrite) begin
          checkOutput("rdata_kept_by_write", bus.line_rdata, lastRead);
          bus.line_write = 1'b0;
        end else begin
          expLine = (rdExpQ.size() > 0) ? rdExpQ.pop_front() : '0;
          checkOutput("line_rdata", bus.line_rdata, expLine);
          lastRead = expLine;
          bus.line_read = 1'b0;
        end
        if (junkInDone) begin
          bus.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
          bus.mem_resp  = 1'b1;
        end
      end else begin
        checkOutput(isWrite ? "strobe_write" : "strobe_read",
                    isWrite ? bus.mem_write : bus.mem_read, 1'b1);
        checkOutput(isWrite ? "other_read_low" : "other_write_low",
                    isWrite ? bus.mem_read : bus.mem_write, 1'b0);
        if (beat < 4) begin
          if (gapCnt < gap) begin
            gapCnt++;
          end else begin
            gapCnt = 0;
            checkOutput("mem_addr", bus.mem_addr, expAddr);
            if (isWrite) begin
              expBeat = (wrBeatQ.size() > 0) ? wrBeatQ.pop_front() : 64'hX;
              checkOutput("mem_wdata", bus.mem_wdata, expBeat);
            end else begin
              bus.mem_rdata = (memBeatQ.size() > 0) ? memBeatQ.pop_front() : 64'h0;
            end
            bus.mem_resp = 1'b1;
            beat++;
          end
        end
      end
    end
    if (!done) begin
      checkOutput("line_resp_timeout", 1'b0, 1'b1);
      bus.line_read  = 1'b0;
      bus.line_write = 1'b0;
    end
    @(negedge clk);
    bus.mem_resp = 1'b0;
    checkOutput("resp_one_cycle", bus.line_resp, 1'b0);
    checkOutput("idle_mem_read", bus.mem_read, 1'b0);
    checkOutput("idle_mem_write", bus.mem_write, 1'b0);
    checkOutput("idle_rdata", bus.line_rdata, lastRead);
  endtask

  task automatic idleJunk(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mem_rdata = {$urandom, $urandom};
      bus.mem_resp  = 1'b1;
      @(negedge clk);
      checkOutput("junk_mem_read", bus.mem_read, 1'b0);
      checkOutput("junk_line_resp", bus.line_resp, 1'b0);
      checkOutput("junk_rdata", bus.line_rdata, lastRead);
    end
    bus.mem_resp = 1'b0;
  endtask

  logic [255:0] rnd;
  logic [63:0]  beatA;
  logic [63:0]  beatB;

  initial begin
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    bus.line_addr  = '0;
    bus.line_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_resp   = 1'b0;
    lastRead       = '0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_read", bus.mem_read, 1'b0);
    checkOutput("rst_mem_write", bus.mem_write, 1'b0);
    checkOutput("rst_line_resp", bus.line_resp, 1'b0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 64'h0);
    checkOutput("rst_line_rdata", bus.line_rdata, 256'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] read with back-to-back beats");
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    serveBurst(1'b0, 0, 1'b1);

    $display("[TB] mem_resp while idle");
    idleJunk(3);

    $display("[TB] write with gapped beats");
    applyStimulus(1'b0, 1'b1, 32'h0000_ABCD,
                  {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                   64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000}, '0);
    serveBurst(1'b1, 2, 1'b0);

    $display("[TB] simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 32'h8000_0040,
                  {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
                   64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000},
                  {64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0002,
                   64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0000});
    serveBurst(1'b1, 0, 1'b0);
    serveBurst(1'b0, 1, 1'b0);

    $display("[TB] reset in the middle of a read");
    beatA = 64'h0123_4567_89AB_CDEF;
    beatB = 64'hFEDC_BA98_7654_3210;
    bus.line_addr = 32'h0000_8000;
    bus.line_read = 1'b1;
    @(negedge clk);
    bus.mem_rdata = beatA;
    bus.mem_resp  = 1'b1;
    @(negedge clk);
    bus.mem_rdata = beatB;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    checkOutput("mid_mem_read", bus.mem_read, 1'b1);
    checkOutput("mid_mem_addr", bus.mem_addr, 32'h0000_8000);
    checkOutput("partial_rdata", bus.line_rdata, {lastRead[255:128], beatB, beatA});
    #2 rst_n = 1'b0;
    bus.line_read = 1'b0;
    #1;
    checkOutput("abort_mem_read", bus.mem_read, 1'b0);
    checkOutput("abort_line_rdata", bus.line_rdata, 256'h0);
    checkOutput("abort_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("abort_line_resp", bus.line_resp, 1'b0);
    #1 rst_n = 1'b1;
    lastRead = '0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_abort_resp", bus.line_resp, 1'b0);
      checkOutput("post_abort_mem_read", bus.mem_read, 1'b0);
    end

    $display("[TB] fresh bursts after reset");
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 1'b0, 32'h0000_8000, '0, rnd);
    serveBurst(1'b0, 3, 1'b1);
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b0, 1'b1, 32'h1234_567F, rnd, '0);
    serveBurst(1'b1, 1, 1'b1);
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, '0, rnd);
    serveBurst(1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/riscy_line_adapter.md
RISCY_LINE_ADAPTER -- requirements
Module: riscy_line_adapter

Interface
REQ-001 Parameters: none; line width fixed at 256 bits, memory beat at 64 bits, burst length fixed at 4 beats.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 line_read  input  1  line fill request from the cache miss path; held until line_resp.
REQ-005 line_write  input  1  line writeback request; held until line_resp.
REQ-006 line_addr  input  32  requested line address; bits [4:0] ignored.
REQ-007 line_wdata  input  256  writeback line; sampled at acceptance.
REQ-008 line_rdata  output  256  assembled fill line.
REQ-009 line_resp  output  1  one-cycle completion pulse to the cache.
REQ-010 mem_read  output  1  burst read strobe to physical memory.
REQ-011 mem_write  output  1  burst write strobe to physical memory.
REQ-012 mem_addr  output  32  line-aligned burst address, bits [4:0] = 0.
REQ-013 mem_wdata  output  64  current write beat.
REQ-014 mem_rdata  input  64  current read beat.
REQ-015 mem_resp  input  1  one pulse per beat accepted or delivered by memory.

Function
REQ-016 The block SHALL implement states IDLE, RBURST, WBURST and DONE, with all outputs driven from registers.
REQ-017 In IDLE with line_write=1, the block SHALL latch {line_addr[31:5],5'b0} and line_wdata, clear the beat counter, and enter WBURST; write wins if both requests are high.
REQ-018 In IDLE with only line_read=1, the block SHALL latch the aligned address, clear the beat counter, and enter RBURST.
REQ-019 mem_read SHALL be high exactly while in RBURST, and mem_write exactly while in WBURST; both are first high the cycle after acceptance.
REQ-020 mem_addr SHALL hold the latched aligned address for the whole burst and never increment.
REQ-021 The 2-bit beat counter k SHALL advance only on mem_resp=1 in RBURST/WBURST and wrap 3->0 on the fourth beat.
REQ-022 In RBURST, each mem_resp SHALL capture mem_rdata into line_rdata[64k+63:64k]; beat 0 is the lowest line bits.
REQ-023 In WBURST, mem_wdata SHALL present latched line_wdata[64k+63:64k] and update on the edge after each mem_resp.
REQ-024 On the fourth mem_resp, the block SHALL enter DONE and deassert mem_read/mem_write in that same next cycle.
REQ-025 In DONE, line_resp SHALL be 1 for exactly one cycle, then the block returns to IDLE unconditionally.
REQ-026 Minimum latency with back-to-back mem_resp SHALL be: acceptance edge 0, strobe cycles 1-4, line_resp in cycle 5.
REQ-027 line_rdata SHALL remain stable from DONE until the first beat of the next read burst, and SHALL be unaffected by write bursts.
REQ-028 mem_resp SHALL be ignored in IDLE and DONE.
REQ-029 Dropping line_read or line_write mid-burst is illegal; the block SHALL still complete all 4 beats and pulse line_resp.
REQ-030 A request still high in the IDLE cycle after DONE SHALL be accepted as a new transaction; requesters drop the request on the edge where line_resp is seen.
REQ-031 Gaps of any length between beats SHALL be tolerated with the strobe held high.

Reset
REQ-032 While rst_n=0, the block SHALL be in IDLE, with k=0, line_resp=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 and line_rdata=0, taking effect immediately and not waiting for clk.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no line_resp, and the first request after release SHALL start a fresh 4-beat burst.

Verification
REQ-034 Read, line_addr=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> mem_addr=0x0000_1220, mem_read cycles 1-4, line_resp cycle 5, line_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-035 Write, line_wdata=256'h{D3,D2,D1,D0}, mem_resp with 2-cycle gaps -> mem_wdata sequence D0,D1,D2,D3, one line_resp, mem_write low in the DONE cycle.
REQ-036 line_read=line_write=1 in IDLE -> write burst runs first, then the held read runs as a separate burst after one IDLE cycle.
REQ-037 rst_n pulsed low after beat 2 of a read -> strobes drop without a clock edge, no line_resp, line_rdata=0, and the next read completes normally.
REQ-038 mem_resp pulses while in IDLE and in DONE -> no state change, k unchanged, and line_rdata unchanged.
